// File: rtl/command_issue_arbiter_pkg.sv
// Shared types for the command issue arbiter: requestor indices and the
// command / response / buffer-status line formats exchanged with producers and PSL.
package command_issue_arbiter_pkg;

    localparam int CMD_ARB_NUM_REQ = 4;

    typedef enum logic [1:0] {
        REQ_WED     = 2'd0,
        REQ_READ    = 2'd1,
        REQ_WRITE   = 2'd2,
        REQ_RESTART = 2'd3
    } cmd_arb_req_e;

    typedef struct packed {
        logic        valid;
        logic [12:0] command;
        logic [63:0] address;
        logic [11:0] size;
        logic [7:0]  tag;
    } CommandBufferLine;

    typedef struct packed {
        logic       valid;
        logic [7:0] tag;
        logic [7:0] response;
        logic [8:0] credits;
    } ResponseBufferLine;

    typedef struct packed {
        logic empty;
        logic alfull;
        logic full;
    } BufferStatus;

    // Round-robin successor of a requestor index, wrapping n-1 -> 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/command_issue_arbiter_fifo_command_line.sv
// Per-requestor synchronous FIFO of CommandBufferLine. The head entry is read
// combinationally so a grant can load it into the output register in the same cycle.
// Fullness is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
module fifo_command_line
    import command_issue_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int ALFULL_MARGIN = 4
) (
    input  logic             clock,
    input  logic             rstn_in,
    input  logic             push,
    input  CommandBufferLine push_data,
    input  logic             pop,
    output CommandBufferLine head,
    output BufferStatus      status,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    CommandBufferLine mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free_entries;
    logic             is_full;
    logic             push_ok;
    logic             pop_ok;

    assign is_full      = (count == CW'(FIFO_DEPTH));
    assign push_ok      = push && !is_full;
    assign pop_ok       = pop && (count != '0);
    assign overflow     = push && is_full;
    assign free_entries = CW'(FIFO_DEPTH) - count;

    assign head          = mem[rd_ptr];
    assign status.empty  = (count == '0);
    assign status.full   = is_full;
    assign status.alfull = (free_entries <= CW'(ALFULL_MARGIN));

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/command_issue_arbiter.sv
// Collects commands from the producers into per-requestor FIFOs and issues one
// per cycle to PSL in round-robin order, limited by the credits PSL granted at enable.
module command_issue_arbiter
    import command_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = CMD_ARB_NUM_REQ,
    parameter int FIFO_DEPTH    = 16,
    parameter int ALFULL_MARGIN = 4,
    parameter int CREDIT_W      = 8
) (
    input  logic                              clock,
    input  logic                              rstn_in,
    input  logic                              enabled_in,
    input  logic [CREDIT_W-1:0]               croom_in,
    input  CommandBufferLine [NUM_REQ-1:0]    command_in,
    input  ResponseBufferLine                 response_in,
    output BufferStatus [NUM_REQ-1:0]         command_buffer_status,
    output CommandBufferLine                  command_out,
    output logic [NUM_REQ-1:0]                overflow_error_out,
    output logic                              credit_error_out
);

    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    CommandBufferLine [NUM_REQ-1:0] fifo_head;
    logic [NUM_REQ-1:0]             fifo_pop;
    logic [NUM_REQ-1:0]             fifo_overflow;
    logic                           enabled_q;
    logic                           enable_rise;
    logic                           grant;
    logic                           grant_found;
    logic [RW-1:0]                  rr_ptr;
    logic [RW-1:0]                  winner;
    logic [RW-1:0]                  cand;
    logic [CREDIT_W-1:0]            credit_count;
    logic [CREDIT_W-1:0]            croom_latched;
    logic                           resp_unused;

    // Only the response valid bit matters here; one response returns one credit.
    assign resp_unused = ^{response_in.tag, response_in.response, response_in.credits};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        fifo_command_line #(
            .FIFO_DEPTH    (FIFO_DEPTH),
            .ALFULL_MARGIN (ALFULL_MARGIN)
        ) u_fifo (
            .clock     (clock),
            .rstn_in   (rstn_in),
            .push      (command_in[i].valid),
            .push_data (command_in[i]),
            .pop       (fifo_pop[i]),
            .head      (fifo_head[i]),
            .status    (command_buffer_status[i]),
            .overflow  (fifo_overflow[i])
        );
        assign fifo_pop[i] = grant && (winner == RW'(i));
    end

    // The enable-rise cycle only latches credits, so it never grants.
    assign enable_rise = enabled_in && !enabled_q;
    assign grant       = enabled_in && !enable_rise && (credit_count != '0) && grant_found;

    // First non-empty requestor at or after the rr pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = RW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && !command_buffer_status[cand].empty) begin
                grant_found = 1'b1;
                winner      = cand;
            end
        end
    end

    // Enable edge detection.
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            enabled_q <= 1'b0;
        end else begin
            enabled_q <= enabled_in;
        end
    end

    // Credit counter: reload on enable, spend on grant, refund on response, capped at croom.
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            credit_count     <= '0;
            croom_latched    <= '0;
            credit_error_out <= 1'b0;
        end else if (enable_rise) begin
            credit_count  <= croom_in;
            croom_latched <= croom_in;
        end else if (grant && !response_in.valid) begin
            credit_count <= credit_count - CREDIT_W'(1);
        end else if (!grant && response_in.valid) begin
            if (credit_count == croom_latched) begin
                credit_error_out <= 1'b1;
            end else begin
                credit_count <= credit_count + CREDIT_W'(1);
            end
        end
    end

    // Round-robin pointer moves just past each winner.
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= RW'(rr_next(int'(winner), NUM_REQ));
        end
    end

    // Output register: one-cycle valid per grant, payload held between grants.
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            command_out <= '0;
        end else if (grant) begin
            command_out <= fifo_head[winner];
        end else begin
            command_out.valid <= 1'b0;
        end
    end

    // Sticky per-requestor record of commands dropped on a full FIFO.
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            overflow_error_out <= '0;
        end else begin
            overflow_error_out <= overflow_error_out | fifo_overflow;
        end
    end

endmodule

// File: tb/tb_command_issue_arbiter.sv
// Directed bench for command_issue_arbiter: a vector table for arbitration and
// credit flow, plus hand-written sequences for reset, fill/overflow and credit corners.
module tb_command_issue_arbiter;
    import command_issue_arbiter_pkg::*;

    logic                        clock;
    logic                        rstn_in;
    logic                        enabled_in;
    logic [7:0]                  croom_in;
    CommandBufferLine [3:0]      command_in;
    ResponseBufferLine           response_in;
    BufferStatus [3:0]           command_buffer_status;
    CommandBufferLine            command_out;
    logic [3:0]                  overflow_error_out;
    logic                        credit_error_out;

    int tests;
    int failed;
    int seq [4];

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] croom;
        logic [3:0] push;
        logic       resp;
        logic       exp_valid;
        logic [7:0] exp_tag;
    } vec_t;

    vec_t vecs[$];

    command_issue_arbiter dut (
        .clock                 (clock),
        .rstn_in               (rstn_in),
        .enabled_in            (enabled_in),
        .croom_in              (croom_in),
        .command_in            (command_in),
        .response_in           (response_in),
        .command_buffer_status (command_buffer_status),
        .command_out           (command_out),
        .overflow_error_out    (overflow_error_out),
        .credit_error_out      (credit_error_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic CommandBufferLine make_cmd(input int req, input int s);
        CommandBufferLine c;
        c.valid   = 1'b1;
        c.command = 13'(16'h0A00 + req);
        c.address = 64'hDEAD_0000_0000_0000 | 64'(req << 16) | 64'(s);
        c.size    = 12'd64;
        c.tag     = {2'(req), 6'(s)};
        return c;
    endfunction

    task automatic drive_push(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                command_in[i] = make_cmd(i, seq[i]);
                seq[i] = seq[i] + 1;
            end else begin
                command_in[i] = '0;
            end
        end
    endtask

    task automatic apply_reset();
        rstn_in     = 1'b0;
        enabled_in  = 1'b0;
        croom_in    = '0;
        command_in  = '0;
        response_in = '0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rstn_in = 1'b1;
        step();
    endtask

    task automatic add_vec(input logic rst, input logic en, input logic [7:0] croom,
                           input logic [3:0] push, input logic resp,
                           input logic exp_valid, input logic [7:0] exp_tag);
        vec_t v;
        v.rst = rst; v.en = en; v.croom = croom; v.push = push;
        v.resp = resp; v.exp_valid = exp_valid; v.exp_tag = exp_tag;
        vecs.push_back(v);
    endtask

    initial begin
        CommandBufferLine exp_cmd;
        int issued;
        int bad;
        logic [7:0] first_tag;

        tests  = 0;
        failed = 0;

        // Credit-limited stream on req1 (croom 2), then returned credits release the rest.
        add_vec(1, 1, 8'd2,  4'b0000, 0, 0, 8'h00);
        add_vec(0, 1, 8'd2,  4'b0010, 0, 0, 8'h00);
        add_vec(0, 1, 8'd2,  4'b0010, 0, 1, 8'h40);
        add_vec(0, 1, 8'd2,  4'b0010, 0, 1, 8'h41);
        add_vec(0, 1, 8'd2,  4'b0010, 0, 0, 8'h00);
        add_vec(0, 1, 8'd2,  4'b0010, 0, 0, 8'h00);
        add_vec(0, 1, 8'd2,  4'b0000, 1, 0, 8'h00);
        add_vec(0, 1, 8'd2,  4'b0000, 1, 1, 8'h42);
        add_vec(0, 1, 8'd2,  4'b0000, 1, 1, 8'h43);
        add_vec(0, 1, 8'd2,  4'b0000, 0, 1, 8'h44);
        add_vec(0, 1, 8'd2,  4'b0000, 0, 0, 8'h00);
        // All four requestors push twice together; round-robin order 0,1,2,3,0,1,2,3.
        add_vec(1, 1, 8'd16, 4'b0000, 0, 0, 8'h00);
        add_vec(0, 1, 8'd16, 4'b1111, 0, 0, 8'h00);
        add_vec(0, 1, 8'd16, 4'b1111, 0, 1, 8'h00);
        add_vec(0, 1, 8'd16, 4'b0000, 0, 1, 8'h40);
        add_vec(0, 1, 8'd16, 4'b0000, 0, 1, 8'h80);
        add_vec(0, 1, 8'd16, 4'b0000, 0, 1, 8'hC0);
        add_vec(0, 1, 8'd16, 4'b0000, 0, 1, 8'h01);
        add_vec(0, 1, 8'd16, 4'b0000, 0, 1, 8'h41);
        add_vec(0, 1, 8'd16, 4'b0000, 0, 1, 8'h81);
        add_vec(0, 1, 8'd16, 4'b0000, 0, 1, 8'hC1);
        add_vec(0, 1, 8'd16, 4'b0000, 0, 0, 8'h00);

        rstn_in     = 1'b0;
        enabled_in  = 1'b0;
        croom_in    = '0;
        command_in  = '0;
        response_in = '0;

        // Reset state, then a single WED command through the two-cycle pipe.
        apply_reset();
        check("reset command_out", 128'(command_out), 128'(0));
        for (int i = 0; i < 4; i++)
            check($sformatf("reset status%0d", i), 128'(command_buffer_status[i]), 128'(3'b100));
        check("reset overflow", 128'(overflow_error_out), 128'(0));
        check("reset credit_error", 128'(credit_error_out), 128'(0));
        check("reset credits", 128'(dut.credit_count), 128'(0));

        enabled_in = 1'b1;
        croom_in   = 8'd4;
        step();
        check("t1 credits latched", 128'(dut.credit_count), 128'(4));
        exp_cmd = make_cmd(REQ_WED, 0);
        drive_push(4'b0001);
        step();
        drive_push(4'b0000);
        check("t1 valid at t+1", 128'(command_out.valid), 128'(0));
        step();
        check("t1 valid at t+2", 128'(command_out.valid), 128'(1));
        check("t1 payload", 128'(command_out), 128'(exp_cmd));
        check("t1 credits after", 128'(dut.credit_count), 128'(3));
        step();
        check("t1 valid one cycle", 128'(command_out.valid), 128'(0));
        check("t1 payload held", 128'(command_out.address), 128'(exp_cmd.address));

        // Vector table.
        foreach (vecs[n]) begin
            if (vecs[n].rst) apply_reset();
            enabled_in  = vecs[n].en;
            croom_in    = vecs[n].croom;
            drive_push(vecs[n].push);
            response_in = '0;
            response_in.valid = vecs[n].resp;
            step();
            check($sformatf("vec%0d valid", n), 128'(command_out.valid), 128'(vecs[n].exp_valid));
            if (vecs[n].exp_valid)
                check($sformatf("vec%0d tag", n), 128'(command_out.tag), 128'(vecs[n].exp_tag));
        end
        drive_push(4'b0000);
        response_in = '0;

        // Fill req0 while disabled: alfull at 12, full at 16, 17th dropped.
        apply_reset();
        for (int k = 1; k <= 17; k++) begin
            drive_push(4'b0001);
            step();
            if (k == 1)  check("t4 not empty", 128'(command_buffer_status[0].empty), 128'(0));
            if (k == 11) check("t4 alfull@11", 128'(command_buffer_status[0].alfull), 128'(0));
            if (k == 12) check("t4 alfull@12", 128'(command_buffer_status[0].alfull), 128'(1));
            if (k == 15) check("t4 full@15", 128'(command_buffer_status[0].full), 128'(0));
            if (k == 16) check("t4 full@16", 128'(command_buffer_status[0].full), 128'(1));
            if (k == 16) check("t4 overflow@16", 128'(overflow_error_out), 128'(0));
            if (k == 17) check("t4 overflow@17", 128'(overflow_error_out), 128'(4'b0001));
        end
        drive_push(4'b0000);
        check("t4 no issue disabled", 128'(command_out.valid), 128'(0));
        enabled_in = 1'b1;
        croom_in   = 8'd32;
        step();
        check("t4 no grant on enable", 128'(command_out.valid), 128'(0));
        issued    = 0;
        bad       = 0;
        first_tag = 8'hFF;
        for (int c = 0; c < 24; c++) begin
            // Push on the first pop cycle while full: must be dropped.
            if (c == 0) drive_push(4'b0001);
            else        drive_push(4'b0000);
            step();
            if (command_out.valid) begin
                if (issued == 0) first_tag = command_out.tag;
                issued++;
                if (command_out.tag[5:0] >= 6'd16) bad++;
            end
        end
        check("t4 drained count", 128'(issued), 128'(16));
        check("t4 dropped never issued", 128'(bad), 128'(0));
        check("t4 first drained", 128'(first_tag), 128'(8'h00));
        check("t4 empty after drain", 128'(command_buffer_status[0].empty), 128'(1));

        // Grant and response together at credits 1, then a response at the cap.
        apply_reset();
        enabled_in = 1'b1;
        croom_in   = 8'd1;
        step();
        drive_push(4'b0001);
        step();
        drive_push(4'b0000);
        response_in.valid = 1'b1;
        step();
        response_in = '0;
        check("t5 grant issued", 128'(command_out.valid), 128'(1));
        check("t5 credits unchanged", 128'(dut.credit_count), 128'(1));
        check("t5 no credit error yet", 128'(credit_error_out), 128'(0));
        response_in.valid = 1'b1;
        step();
        response_in = '0;
        check("t5 credit error", 128'(credit_error_out), 128'(1));
        check("t5 credits capped", 128'(dut.credit_count), 128'(1));

        // Asynchronous reset in the middle of a burst.
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive_push(4'b0100);
            step();
        end
        drive_push(4'b0000);
        enabled_in = 1'b1;
        croom_in   = 8'd4;
        step();
        step();
        check("t6 valid before reset", 128'(command_out.valid), 128'(1));
        check("t6 tag before reset", 128'(command_out.tag), 128'(8'h80));
        #2;
        rstn_in = 1'b0;
        #1;
        check("t6 valid in reset", 128'(command_out.valid), 128'(0));
        check("t6 payload in reset", 128'(command_out), 128'(0));
        check("t6 empty in reset", 128'(command_buffer_status[2].empty), 128'(1));
        enabled_in = 1'b0;
        @(negedge clock);
        rstn_in = 1'b1;
        step();
        enabled_in = 1'b1;
        croom_in   = 8'd8;
        step();
        check("t6 credits reloaded", 128'(dut.credit_count), 128'(8));
        issued = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (command_out.valid) issued++;
        end
        check("t6 no stale issue", 128'(issued), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
